// File: rtl/source_seq_pkg.sv
// Shared definitions for the multi-channel sample sequencer.
// Register offsets inside a channel's control window, CTRL/STATUS bit
// positions, and the FSM state encodings used by the top and by each channel.
package source_seq_pkg;

  // Control-window offsets (reg_addr[10:0] when reg_addr[11] = 1)
  localparam logic [10:0] OffCtrl      = 11'd0;
  localparam logic [10:0] OffStartAddr = 11'd1;
  localparam logic [10:0] OffLen       = 11'd2;
  localparam logic [10:0] OffLoops     = 11'd3;
  localparam logic [10:0] OffStatus    = 11'd4;

  // CTRL bits (write-only, self-clearing)
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlStopBit  = 1;

  // STATUS bits
  localparam int unsigned StatBusyBit = 0;
  localparam int unsigned StatDoneBit = 1;
  localparam int unsigned StatErrBit  = 2;

  typedef enum logic [1:0] {StIdle, StPrime, StPlay} chan_state_e;

  typedef enum logic [1:0] {RegIdle, RegWait, RegAck, RegDrop} reg_state_e;

endpackage

// File: rtl/source_seq_chan.sv
// One playback channel: sample RAM (register write/read port plus a playback
// read port, both 1-cycle latency), control registers, FSM, shadows, loop
// counter and a two-deep output buffer (output register + skid entry).
// Ports:
//   pcm_clk, rst_n      clock, async active-low reset
//   mem_we, ctrl_we     decoded write strobes for this channel
//   reg_off, reg_wdata  register offset / write data
//   mem_rdata           RAM word at reg_off, registered
//   ctrl_rdata          control register at reg_off, combinational
//   out_valid/ready/data  sample stream, done_irq completion pulse
module source_seq_chan
  import source_seq_pkg::*;
#(
  parameter int unsigned PCMAW = 12,
  parameter int unsigned LOOPW = 16
) (
  input  logic        pcm_clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        ctrl_we,
  input  logic [10:0] reg_off,
  input  logic [31:0] reg_wdata,
  output logic [31:0] mem_rdata,
  output logic [31:0] ctrl_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        done_irq
);

  localparam int unsigned Words = 2 ** (PCMAW - 1);

  logic [31:0] mem [Words];
  logic [31:0] rd_word_q;
  logic        half_q;

  logic [PCMAW-1:0] start_addr_q;
  logic [PCMAW:0]   len_q;
  logic [LOOPW-1:0] loops_q;

  chan_state_e      state_q, state_d;
  logic [PCMAW-1:0] start_s_q, start_s_d, addr_q, addr_d;
  logic [PCMAW:0]   len_s_q, len_s_d, cnt_q, cnt_d;
  logic [LOOPW-1:0] passes_q, passes_d;
  logic             loops_inf_q, loops_inf_d, issue_done_q, issue_done_d;
  logic             inflight_q, inflight_d, out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d, done_q, done_d, err_q, err_d;
  logic             done_irq_q, done_irq_d;
  logic [15:0]      out_data_q, out_data_d, skid_data_q, skid_data_d;

  logic        ctrl_wr, status_wr, stop_cmd, start_cmd, start_ok, start_err;
  logic        xfer, issue, finish, done_keep;
  logic [2:0]  occ;
  logic [15:0] rd_sample;

  assign ctrl_wr   = ctrl_we && (reg_off == OffCtrl);
  assign status_wr = ctrl_we && (reg_off == OffStatus);
  assign stop_cmd  = ctrl_wr && reg_wdata[CtrlStopBit];
  assign start_cmd = ctrl_wr && reg_wdata[CtrlStartBit];
  assign start_ok  = start_cmd && !stop_cmd && (len_q != '0);
  assign start_err = start_cmd && (len_q == '0);

  // RAM: no reset on contents
  always_ff @(posedge pcm_clk) begin
    if (mem_we) mem[reg_off[PCMAW-2:0]] <= reg_wdata;
    mem_rdata <= mem[reg_off[PCMAW-2:0]];
    rd_word_q <= mem[addr_q[PCMAW-1:1]];
    half_q    <= addr_q[0];
  end

  always_ff @(posedge pcm_clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr_q <= '0;
      len_q        <= '0;
      loops_q      <= '0;
    end else if (ctrl_we) begin
      case (reg_off)
        OffStartAddr: start_addr_q <= reg_wdata[PCMAW-1:0];
        OffLen:       len_q        <= reg_wdata[PCMAW:0];
        OffLoops:     loops_q      <= reg_wdata[LOOPW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    start_s_d    = start_s_q;
    len_s_d      = len_s_q;
    loops_inf_d  = loops_inf_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    passes_d     = passes_q;
    issue_done_d = issue_done_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    err_d        = err_q;
    done_irq_d   = 1'b0;

    rd_sample = half_q ? rd_word_q[31:16] : rd_word_q[15:0];
    xfer      = out_valid_q && out_ready;
    // Entries that will hold data after this edge; a new read may be issued
    // only if its data is guaranteed a slot one cycle later.
    occ   = 3'(out_valid_q) + 3'(skid_valid_q) + 3'(inflight_q) - 3'(xfer);
    issue = (state_q != StIdle) && !issue_done_q && (occ < 3'd2);

    if (issue) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == 1) begin
        addr_d = start_s_q;
        cnt_d  = len_s_q;
        if (!loops_inf_q) begin
          if (passes_q > 1) begin
            passes_d = passes_q - 1'b1;
          end else begin
            passes_d     = '0;
            issue_done_d = 1'b1;
          end
        end
      end
    end
    inflight_d = issue;

    if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = inflight_q;
        skid_data_d  = rd_sample;
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_sample;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_sample;
    end

    done_keep = done_q && !(status_wr && reg_wdata[StatDoneBit]);
    done_d    = done_keep;
    if (status_wr && reg_wdata[StatErrBit]) err_d = 1'b0;
    if (start_err) err_d = 1'b1;

    finish = (state_q == StPlay) && issue_done_q && !inflight_q && !skid_valid_q && xfer;
    if (state_q == StPrime && out_valid_d) state_d = StPlay;
    if (finish) begin
      state_d    = StIdle;
      done_d     = 1'b1;
      done_irq_d = 1'b1;
    end

    // STOP/START flush everything in flight; STOP wins over a finishing pass
    if (stop_cmd || start_ok) begin
      state_d      = StIdle;
      inflight_d   = 1'b0;
      issue_done_d = 1'b0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      done_d       = done_keep;
      done_irq_d   = 1'b0;
      if (!stop_cmd) begin
        state_d     = StPrime;
        start_s_d   = start_addr_q;
        len_s_d     = len_q;
        loops_inf_d = (loops_q == '0);
        addr_d      = start_addr_q;
        cnt_d       = len_q;
        passes_d    = loops_q;
      end
    end
  end

  always_ff @(posedge pcm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_s_q    <= '0;
      len_s_q      <= '0;
      loops_inf_q  <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      passes_q     <= '0;
      issue_done_q <= 1'b0;
      inflight_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_irq_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_s_q    <= start_s_d;
      len_s_q      <= len_s_d;
      loops_inf_q  <= loops_inf_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      passes_q     <= passes_d;
      issue_done_q <= issue_done_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      done_irq_q   <= done_irq_d;
    end
  end

  always_comb begin
    ctrl_rdata = '0;
    case (reg_off)
      OffStartAddr: ctrl_rdata = 32'(start_addr_q);
      OffLen:       ctrl_rdata = 32'(len_q);
      OffLoops:     ctrl_rdata = 32'(loops_q);
      OffStatus: begin
        ctrl_rdata[31:16]       = 16'(passes_q);
        ctrl_rdata[StatBusyBit] = (state_q != StIdle);
        ctrl_rdata[StatDoneBit] = done_q;
        ctrl_rdata[StatErrBit]  = err_q;
      end
      default: ;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? out_data_q : '0;
  assign done_irq  = done_irq_q;

endmodule

// File: rtl/source_seq.sv
// Multi-channel sample sequencer top: register-port handshake and decode,
// read-data mux, and CHANNEL instances of source_seq_chan.
// Ports:
//   pcm_clk, rst_n                    clock, async active-low reset
//   reg_addr/rd/wr/writedata          register access request
//   reg_readdata, reg_ready           access completion
//   pcm_out_valid/ready, pcm_out      per-channel sample streams
//   done_irq                          per-channel completion pulse
module source_seq
  import source_seq_pkg::*;
#(
  parameter int unsigned CHANNEL = 4,
  parameter int unsigned PCMAW   = 12,
  parameter int unsigned LOOPW   = 16
) (
  input  logic                  pcm_clk,
  input  logic                  rst_n,
  input  logic [15:0]           reg_addr,
  input  logic                  reg_rd,
  input  logic                  reg_wr,
  input  logic [31:0]           reg_writedata,
  output logic [31:0]           reg_readdata,
  output logic                  reg_ready,
  output logic [CHANNEL-1:0]    pcm_out_valid,
  input  logic [CHANNEL-1:0]    pcm_out_ready,
  output logic [16*CHANNEL-1:0] pcm_out,
  output logic [CHANNEL-1:0]    done_irq
);

  reg_state_e  reg_st_q, reg_st_d;
  logic        strobe, wr_fire, is_ctrl, mem_ok;
  logic [3:0]  ch_idx;
  logic [31:0] rd_sel, readdata_q;
  logic [31:0] mem_rd  [CHANNEL];
  logic [31:0] ctrl_rd [CHANNEL];

  assign strobe  = reg_rd || reg_wr;
  assign ch_idx  = reg_addr[15:12];
  assign is_ctrl = reg_addr[11];
  assign mem_ok  = (reg_addr[10:0] >> (PCMAW - 1)) == '0;
  // Side effects commit in the single cycle reg_ready is high
  assign wr_fire = (reg_st_q == RegAck) && reg_wr;

  always_comb begin
    reg_st_d = reg_st_q;
    case (reg_st_q)
      RegIdle: if (strobe) reg_st_d = RegWait;
      RegWait: reg_st_d = RegAck;
      RegAck:  reg_st_d = RegDrop;
      RegDrop: if (!strobe) reg_st_d = RegIdle;
      default: reg_st_d = RegIdle;
    endcase
  end

  // Channels beyond CHANNEL match no loop index and read as 0
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      if (ch_idx == 4'(k)) rd_sel = is_ctrl ? ctrl_rd[k] : (mem_ok ? mem_rd[k] : '0);
    end
  end

  always_ff @(posedge pcm_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_st_q   <= RegIdle;
      readdata_q <= '0;
    end else begin
      reg_st_q <= reg_st_d;
      if (reg_st_q == RegWait) readdata_q <= rd_sel;
    end
  end

  assign reg_ready    = (reg_st_q == RegAck);
  assign reg_readdata = readdata_q;

  for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
    logic sel;
    assign sel = (ch_idx == 4'(k));

    source_seq_chan #(
      .PCMAW (PCMAW),
      .LOOPW (LOOPW)
    ) u_chan (
      .pcm_clk    (pcm_clk),
      .rst_n      (rst_n),
      .mem_we     (wr_fire && sel && !is_ctrl && mem_ok),
      .ctrl_we    (wr_fire && sel && is_ctrl),
      .reg_off    (reg_addr[10:0]),
      .reg_wdata  (reg_writedata),
      .mem_rdata  (mem_rd[k]),
      .ctrl_rdata (ctrl_rd[k]),
      .out_valid  (pcm_out_valid[k]),
      .out_ready  (pcm_out_ready[k]),
      .out_data   (pcm_out[16*k +: 16]),
      .done_irq   (done_irq[k])
    );
  end

endmodule
